nn_argmax: RTL and testbench
============================

Name: nn_argmax

Overview:
- Downstream stage of the per-neuron multiply-accumulate/activation block.
- After the last layer's neuron results are written to the output BRAM, this block scans `count` consecutive signed 32-bit result words.
- It reports the index and value of the largest word, i.e. the MNIST class decision.
- It is a start/done slave of the layer sequencer and is the only reader of the output BRAM port it owns during a scan.

Parameters:
- ADDR_W, 32, byte-address width of the output BRAM port.
- CNT_W, 8, width of `count` (maximum 255 words scanned).
- IDX_W, 8, width of `class_idx`.

Ports:
- nnclk  in  1  sole clock; all logic on the rising edge.
- nnrst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of word 0; must be a multiple of 4.
- count  in  CNT_W  number of 32-bit words to scan.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- class_idx  out  IDX_W  index (0-based) of the maximum word.
- max_val  out  32  signed value of the maximum word.
- output_addr  out  ADDR_W  BRAM byte address.
- output_en  out  1  BRAM enable.
- output_we  out  4  BRAM byte write enables; always 0.
- output_din  out  32  BRAM write data; always 0.
- output_dout  in  32  BRAM read data; valid 1 cycle after address/enable (registered read).

Behaviour:
- Reset (nnrst=1 at an edge): applies in any state, including mid-scan; the scan is abandoned with no done pulse.
  - state=IDLE.
  - busy=0, done=0, class_idx=0, max_val=0.
  - output_addr=0, output_en=0.
  - output_we=0 and output_din=0 permanently.
- States: IDLE, READ, DRAIN, FINISH.
- IDLE:
  - On an edge with start=1 and count>0: latch base_addr and count; drive output_addr<=base_addr, output_en<=1; clear the internal issue counter and receive counter; set the running best to 32'h80000000 with index 0; busy<=1; go to READ.
  - On start=1 with count=0: go straight to FINISH with class_idx=0, max_val=32'h80000000.
- READ:
  - One address is issued per cycle; output_addr increments by 4 each edge.
  - output_dout for address k is consumed at the edge after address k was presented (1-cycle pipeline).
  - Each received word is compared as signed 32-bit against the running best.
  - The running best is replaced only if the word is strictly greater, so on ties the lowest index wins.
  - When the last address (index count-1) has been presented: output_en<=0 at that edge, go to DRAIN.
- DRAIN: consume and compare the final word; go to FINISH.
- FINISH:
  - Register class_idx and max_val from the running best; done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: for count=N≥1, done is high in the cycle beginning N+2 edges after the start edge. Throughput is 1 word/cycle.
- class_idx and max_val hold their values until the next FINISH or reset; they are not cleared on start.
- start while busy: ignored, and not queued.
- base_addr and count are sampled only at acceptance; later changes have no effect on the current scan.
- Address arithmetic wraps modulo 2^ADDR_W. No bounds checking is done.
- done and start may be high in the same cycle. The new start is accepted, because the block is in IDLE once done is registered.

Test Plan:
- Reset mid-scan:
  - Stimulus: nnrst pulsed while in READ with count=10.
  - Required response: next cycle busy=0, output_en=0, class_idx=0, max_val=0, and no done pulse.
- Basic scan:
  - Stimulus: BRAM words at 0x100.. = {5, -3, 42, 7, 41, 0, -128, 9, 1, 2}; base_addr=0x100, count=10; start 1 cycle.
  - Required response: output_addr steps 0x100..0x124 on consecutive cycles; done pulses once 12 edges after start; class_idx=2, max_val=42; output_we stays 0 throughout.
- Ties and negatives:
  - Stimulus: words {-7, -2, -2, -9}, count=4.
  - Required response: class_idx=1, max_val=-2 (lowest index wins). All-equal words {3, 3, 3} give class_idx=0.
- Edge counts:
  - Stimulus: count=1 with word 32'h80000000.
  - Required response: class_idx=0, max_val=32'h80000000, done 3 edges after start.
  - Stimulus: count=0.
  - Required response: done the next cycle, no BRAM enable, max_val=32'h80000000.
- Handshake robustness:
  - Stimulus: start held high for 20 cycles, and count changed mid-scan.
  - Required response: exactly one scan per acceptance; a second scan starts in the cycle done is high; results reflect the original count.
- Large value extremes:
  - Stimulus: count=255 with the maximum 32'h7FFFFFFF at index 254.
  - Required response: class_idx=254, done at edge 257.

Source files
------------

// File: rtl/nn_argmax.sv
// Scans `count` signed 32-bit words from the output BRAM and reports the index
// and value of the largest one (lowest index wins on ties).
module nn_argmax #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8,
    parameter int IDX_W  = 8
) (
    input  logic                     nnclk,
    input  logic                     nnrst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         count,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [31:0]       max_val,
    output logic [ADDR_W-1:0]        output_addr,
    output logic                     output_en,
    output logic [3:0]               output_we,
    output logic [31:0]              output_din,
    input  logic [31:0]              output_dout
);

    localparam int DATA_W = 32;
    localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]        ADDR_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          issue_cnt;
    logic [CNT_W-1:0]          recv_cnt_p1;
    logic                      vld_p1;
    logic signed [DATA_W-1:0]  word_p1;
    logic signed [DATA_W-1:0]  best_val;
    logic [CNT_W-1:0]          best_idx;

    function automatic logic beats(input logic signed [DATA_W-1:0] cand,
                                   input logic signed [DATA_W-1:0] best);
        return cand > best;
    endfunction

    assign output_we  = '0;
    assign output_din = '0;
    assign word_p1    = output_dout;

    always_ff @(posedge nnclk) begin
        if (nnrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (count == '0) ? FINISH : READ;
            READ:    if (issue_cnt == cnt_q - CNT_ONE) state_nxt = DRAIN;
            DRAIN:   state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nnclk) begin
        if (nnrst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            class_idx   <= '0;
            max_val     <= '0;
            output_addr <= '0;
            output_en   <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            done   <= 1'b0;
            // stage p1: BRAM captured an address at this edge, data usable next edge
            vld_p1 <= output_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        cnt_q       <= count;
                        issue_cnt   <= '0;
                        recv_cnt_p1 <= '0;
                        best_val    <= MIN_VAL;
                        best_idx    <= '0;
                        if (count != '0) begin
                            output_addr <= base_addr;
                            output_en   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue_cnt == cnt_q - CNT_ONE) begin
                        output_en <= 1'b0;
                    end else begin
                        output_addr <= output_addr + ADDR_STEP;
                        issue_cnt   <= issue_cnt + CNT_ONE;
                    end
                end
                FINISH: begin
                    class_idx <= IDX_W'(best_idx);
                    max_val   <= best_val;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
            // stage p2: compare the returned word against the running best
            if (vld_p1) begin
                if (beats(word_p1, best_val)) begin
                    best_val <= word_p1;
                    best_idx <= recv_cnt_p1;
                end
                recv_cnt_p1 <= recv_cnt_p1 + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_nn_argmax.sv
// Bench for nn_argmax: BRAM model with registered read, randomized scans
// compared against a plain-loop argmax reference.
module tb_nn_argmax;

    logic               nnclk = 1'b0;
    logic               nnrst, start;
    logic [31:0]        base_addr;
    logic [7:0]         count;
    logic               busy, done;
    logic [7:0]         class_idx;
    logic signed [31:0] max_val;
    logic [31:0]        output_addr;
    logic               output_en;
    logic [3:0]         output_we;
    logic [31:0]        output_din;
    logic [31:0]        output_dout;

    int tests = 0;
    int fails = 0;

    logic [31:0]        mem      [0:1023];
    logic signed [31:0] wbuf     [0:255];
    logic [31:0]        addr_log [0:4095];
    int addr_n   = 0;
    int done_n   = 0;
    int side_bad = 0;

    always #5 nnclk = ~nnclk;

    nn_argmax #(.ADDR_W(32), .CNT_W(8), .IDX_W(8)) dut (
        .nnclk(nnclk), .nnrst(nnrst), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .class_idx(class_idx),
        .max_val(max_val), .output_addr(output_addr), .output_en(output_en),
        .output_we(output_we), .output_din(output_din), .output_dout(output_dout)
    );

    always @(posedge nnclk) begin
        if (output_en) begin
            output_dout <= mem[output_addr[11:2]];
            addr_log[addr_n % 4096] <= output_addr;
            addr_n <= addr_n + 1;
        end
    end

    always @(negedge nnclk) begin
        if (done) done_n <= done_n + 1;
        if (output_we !== 4'b0 || output_din !== 32'b0) side_bad <= side_bad + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge nnclk);
        #1;
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) mem[(int'(base[11:2]) + i) % 1024] = wbuf[i];
    endtask

    function automatic void ref_argmax(input int n, output int idx, output logic signed [31:0] val);
        val = 32'sh80000000;
        idx = 0;
        for (int i = 0; i < n; i++) begin
            if (wbuf[i] > val) begin
                val = wbuf[i];
                idx = i;
            end
        end
    endfunction

    task automatic do_scan(input logic [31:0] base, input int n, output int lat,
                           output logic addr_ok, output int dones);
        int a0, d0;
        logic [31:0] ea;
        a0 = addr_n;
        d0 = done_n;
        base_addr = base;
        count = 8'(n);
        start = 1'b1;
        @(posedge nnclk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge nnclk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        tick(2);
        dones = done_n - d0;
        addr_ok = (addr_n - a0 == n);
        for (int i = 0; i < n; i++) begin
            ea = base + 32'(4 * i);
            if (addr_log[(a0 + i) % 4096] !== ea) addr_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        nnrst = 1'b1; start = 1'b0; count = '0; base_addr = '0;
        tick(3);
        nnrst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (class_idx !== 8'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", class_idx); end
        tests++; if (max_val !== 32'sd0) begin fails++; $display("FAIL reset_max: got %0d want 0", max_val); end
        tests++; if (output_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", output_en); end
        tests++; if (output_addr !== 32'd0) begin fails++; $display("FAIL reset_addr: got %h want 0", output_addr); end
    endtask

    task automatic test_basic();
        int vals [10] = '{5, -3, 42, 7, 41, 0, -128, 9, 1, 2};
        int lat, dones;
        logic aok;
        for (int i = 0; i < 10; i++) wbuf[i] = vals[i];
        load(32'h100, 10);
        do_scan(32'h100, 10, lat, aok, dones);
        tests++; if (lat !== 12) begin fails++; $display("FAIL basic_latency: got %0d want 12", lat); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL basic_done_pulses: got %0d want 1", dones); end
        tests++; if (aok !== 1'b1) begin fails++; $display("FAIL basic_addr_seq: got %b want 1", aok); end
        tests++; if (class_idx !== 8'd2) begin fails++; $display("FAIL basic_idx: got %0d want 2", class_idx); end
        tests++; if (max_val !== 32'sd42) begin fails++; $display("FAIL basic_max: got %0d want 42", max_val); end
    endtask

    task automatic test_reset_mid();
        int d0;
        for (int i = 0; i < 10; i++) wbuf[i] = $urandom;
        load(32'h200, 10);
        d0 = done_n;
        base_addr = 32'h200; count = 8'd10; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        nnrst = 1'b1;
        tick(1);
        nnrst = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tests++; if (output_en !== 1'b0) begin fails++; $display("FAIL midrst_en: got %b want 0", output_en); end
        tests++; if (class_idx !== 8'd0) begin fails++; $display("FAIL midrst_idx: got %0d want 0", class_idx); end
        tests++; if (max_val !== 32'sd0) begin fails++; $display("FAIL midrst_max: got %0d want 0", max_val); end
        tick(20);
        tests++; if (done_n !== d0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_n - d0); end
    endtask

    task automatic test_ties();
        int lat, dones;
        logic aok;
        wbuf[0] = -7; wbuf[1] = -2; wbuf[2] = -2; wbuf[3] = -9;
        load(32'h300, 4);
        do_scan(32'h300, 4, lat, aok, dones);
        tests++; if (lat !== 6) begin fails++; $display("FAIL ties_latency: got %0d want 6", lat); end
        tests++; if (class_idx !== 8'd1) begin fails++; $display("FAIL ties_idx: got %0d want 1", class_idx); end
        tests++; if (max_val !== -32'sd2) begin fails++; $display("FAIL ties_max: got %0d want -2", max_val); end
        wbuf[0] = 3; wbuf[1] = 3; wbuf[2] = 3;
        load(32'h340, 3);
        do_scan(32'h340, 3, lat, aok, dones);
        tests++; if (class_idx !== 8'd0) begin fails++; $display("FAIL equal_idx: got %0d want 0", class_idx); end
        tests++; if (max_val !== 32'sd3) begin fails++; $display("FAIL equal_max: got %0d want 3", max_val); end
    endtask

    task automatic test_random();
        int n, lat, dones, eidx;
        logic aok;
        logic signed [31:0] eval;
        logic [31:0] base;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 40);
            base = (it == 0) ? 32'hFFFF_FFE0 : ($urandom & 32'hFFFF_FFFC);
            for (int i = 0; i < n; i++)
                wbuf[i] = (it % 2 == 0) ? $signed($urandom) : ($urandom_range(0, 7) - 4);
            load(base, n);
            ref_argmax(n, eidx, eval);
            do_scan(base, n, lat, aok, dones);
            tests++; if (lat !== n + 2) begin fails++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, n + 2); end
            tests++; if (dones !== 1) begin fails++; $display("FAIL rand%0d_done_pulses: got %0d want 1", it, dones); end
            tests++; if (aok !== 1'b1) begin fails++; $display("FAIL rand%0d_addr_seq: got %b want 1", it, aok); end
            tests++; if (class_idx !== 8'(eidx)) begin fails++; $display("FAIL rand%0d_idx: got %0d want %0d", it, class_idx, eidx); end
            tests++; if (max_val !== eval) begin fails++; $display("FAIL rand%0d_max: got %0d want %0d", it, max_val, eval); end
        end
    endtask

    task automatic test_edge_counts();
        int lat, dones;
        logic aok;
        wbuf[0] = 1; wbuf[1] = 9;
        load(32'h400, 2);
        do_scan(32'h400, 2, lat, aok, dones);
        tests++; if (class_idx !== 8'd1) begin fails++; $display("FAIL pre1_idx: got %0d want 1", class_idx); end
        wbuf[0] = 32'sh80000000;
        load(32'h410, 1);
        do_scan(32'h410, 1, lat, aok, dones);
        tests++; if (lat !== 3) begin fails++; $display("FAIL cnt1_latency: got %0d want 3", lat); end
        tests++; if (class_idx !== 8'd0) begin fails++; $display("FAIL cnt1_idx: got %0d want 0", class_idx); end
        tests++; if (max_val !== 32'sh80000000) begin fails++; $display("FAIL cnt1_max: got %h want 80000000", max_val); end
        wbuf[0] = 1; wbuf[1] = 9;
        load(32'h400, 2);
        do_scan(32'h400, 2, lat, aok, dones);
        tests++; if (max_val !== 32'sd9) begin fails++; $display("FAIL pre0_max: got %0d want 9", max_val); end
        do_scan(32'h420, 0, lat, aok, dones);
        tests++; if (lat !== 1) begin fails++; $display("FAIL cnt0_latency: got %0d want 1", lat); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL cnt0_done_pulses: got %0d want 1", dones); end
        tests++; if (aok !== 1'b1) begin fails++; $display("FAIL cnt0_no_bram: got %b want 1", aok); end
        tests++; if (class_idx !== 8'd0) begin fails++; $display("FAIL cnt0_idx: got %0d want 0", class_idx); end
        tests++; if (max_val !== 32'sh80000000) begin fails++; $display("FAIL cnt0_max: got %h want 80000000", max_val); end
    endtask

    task automatic test_back_to_back();
        int eidx, t, nexp, ngot, lat;
        int exp_edges [8];
        int got_edges [8];
        logic signed [31:0] eval;
        // start held for edges 0..19 with a 6-word scan
        for (int i = 0; i < 6; i++) wbuf[i] = $signed($urandom);
        load(32'h500, 6);
        ref_argmax(6, eidx, eval);
        nexp = 0;
        t = 0;
        while (t <= 19) begin
            exp_edges[nexp] = t + 8;
            nexp++;
            t = t + 9;
        end
        ngot = 0;
        base_addr = 32'h500; count = 8'd6; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge nnclk);
            #1;
            if (k == 19) start = 1'b0;
            if (done) begin
                if (ngot < 8) got_edges[ngot] = k;
                ngot++;
                tests++; if (class_idx !== 8'(eidx)) begin fails++; $display("FAIL held_idx: got %0d want %0d", class_idx, eidx); end
                tests++; if (max_val !== eval) begin fails++; $display("FAIL held_max: got %0d want %0d", max_val, eval); end
            end
        end
        tests++; if (ngot !== nexp) begin fails++; $display("FAIL held_scan_count: got %0d want %0d", ngot, nexp); end
        for (int i = 0; i < nexp && i < ngot; i++) begin
            tests++; if (got_edges[i] !== exp_edges[i]) begin fails++; $display("FAIL held_done_edge%0d: got %0d want %0d", i, got_edges[i], exp_edges[i]); end
        end
        // count and base changed mid-scan must not affect the running scan
        for (int i = 0; i < 10; i++) wbuf[i] = $signed($urandom);
        load(32'h600, 10);
        ref_argmax(10, eidx, eval);
        for (int i = 0; i < 2; i++) mem[(32'h700 >> 2) + i] = 32'h7FFF_FFFF;
        base_addr = 32'h600; count = 8'd10; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        count = 8'd2; base_addr = 32'h700;
        lat = -1;
        for (int k = 4; k <= 300; k++) begin
            @(posedge nnclk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        tests++; if (lat !== 12) begin fails++; $display("FAIL chg_latency: got %0d want 12", lat); end
        tests++; if (class_idx !== 8'(eidx)) begin fails++; $display("FAIL chg_idx: got %0d want %0d", class_idx, eidx); end
        tests++; if (max_val !== eval) begin fails++; $display("FAIL chg_max: got %0d want %0d", max_val, eval); end
        tick(2);
    endtask

    task automatic test_large();
        int lat, dones;
        logic aok;
        for (int i = 0; i < 255; i++) begin
            wbuf[i] = $signed($urandom);
            if (wbuf[i] == 32'sh7FFFFFFF) wbuf[i] = 0;
        end
        wbuf[254] = 32'sh7FFFFFFF;
        load(32'h0, 255);
        do_scan(32'h0, 255, lat, aok, dones);
        tests++; if (lat !== 257) begin fails++; $display("FAIL large_latency: got %0d want 257", lat); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL large_done_pulses: got %0d want 1", dones); end
        tests++; if (aok !== 1'b1) begin fails++; $display("FAIL large_addr_seq: got %b want 1", aok); end
        tests++; if (class_idx !== 8'd254) begin fails++; $display("FAIL large_idx: got %0d want 254", class_idx); end
        tests++; if (max_val !== 32'sh7FFFFFFF) begin fails++; $display("FAIL large_max: got %h want 7fffffff", max_val); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid();
        test_ties();
        test_random();
        test_edge_counts();
        test_back_to_back();
        test_large();
        tests++; if (side_bad !== 0) begin fails++; $display("FAIL write_side_zero: got %0d bad cycles want 0", side_bad); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
